aes_cipher_core: RTL and testbench
==================================

Name: aes_cipher_core

Overview:
- Iterative AES-128 encryption datapath. Sits directly downstream of the round-key expansion stage and consumes one 128-bit round key per cycle.
- Runs the initial AddRoundKey, rounds 1..9 (full) and round 10 (no MixColumns), one per cycle.
- Sequences the key expansion by pulsing its restart, so round key r arrives exactly in round-cycle r.
- Result is held with a done flag until the next start.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported. Any other value is a configuration error.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; clock clk
- start  input  1  request to encrypt plaintext; accepted only when ready=1
- plaintext  input  128  input block, byte 0 = bits[127:120], column-major per FIPS-197
- round_key  input  128  round key from key expansion; key for round r valid in round-cycle r
- ready  output  1  high in IDLE and DONE (start will be accepted)
- kx_restart  output  1  combinational pulse to key expansion reset = start & ready
- busy  output  1  high while rounds are in progress
- done  output  1  high while ciphertext holds a completed result
- ciphertext  output  128  encrypted block, registered, held until the next accepted start

Behaviour:
- Reset values: state=IDLE, round counter=0, state register=0, ciphertext=0, done=0, busy=0, ready=1. kx_restart=0 unless start is high.
- FSM states: IDLE, ROUND, DONE.
  - IDLE -start-> ROUND.
  - ROUND (cnt 0..10) -cnt==10-> DONE.
  - DONE -start-> ROUND.
  - DONE with no start stays in DONE.
- Accept cycle T (start & ready): plaintext is latched into the input register, kx_restart=1, cnt<=0, done<=0.
- kx_restart resets the key expansion on edge T, so round_key equals the cipher key at T+1.
- Round-cycle 0 (T+1): st <= pt ^ round_key.
- Round-cycles 1..9 (T+2..T+10): st <= MixColumns(ShiftRows(SubBytes(st))) ^ round_key.
- Round-cycle 10 (T+11): ciphertext <= ShiftRows(SubBytes(st)) ^ round_key. Then state<=DONE and done<=1.
- Latency: done rises at T+12, i.e. 12 cycles after the accepting edge.
- Throughput: one block per 12 cycles when start is held high in DONE.
- busy=1 exactly in ROUND. ready = !busy.
- start while busy: ignored. No kx_restart, no latch, no effect on the running round.
- start in DONE: accepted. done drops on the next edge. ciphertext keeps the old value until T+11 of the new block.
- Reset mid-operation: returns to IDLE next edge, ciphertext=0, done=0, partial state discarded.
  - The key expansion is reset independently by the system reset.
- Datapath:
  - 16 S-box lookups, combinational, FIPS-197 table.
  - ShiftRows: row r is rotated left by r bytes.
  - MixColumns: xtime = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00). Matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
  - All arithmetic is GF(2^8), 8-bit, with no width growth.
- Round counter: 4 bits. Saturates at 10. It is not advanced outside ROUND.
- plaintext and round_key are sampled only on the cycles listed above. Changes at other times have no effect.

Test Plan:
- FIPS-197 App. B with behavioural key-expansion model in loop.
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, start at T.
  - Required: kx_restart=1 only at T, busy T+1..T+11, ciphertext 3925841d02dc09fbdc118597196a0b32, done=1 from T+12.
- FIPS-197 App. C.1.
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: ct 69c4e0d86a7b0430d8cdb78070b4c55a. Intermediate st after round 1 = 89d810e8855ace682d1843d8cb128fe4.
- Back-to-back: start held high.
  - Required: second block accepted in first DONE cycle, done low one cycle later, second result at +12. Results match the App. B and C.1 vectors in order.
- Start while busy: pulse start at T+5 with different plaintext.
  - Required: no kx_restart, ciphertext still App. B value at T+12, ready=0 T+1..T+11.
- Reset at T+6 mid-encryption.
  - Required: next cycle state IDLE, done=0, ciphertext=0, ready=1. Subsequent C.1 run is correct.
- Hold in DONE 20 cycles with start=0 and plaintext toggling.
  - Required: ciphertext and done stable, busy=0, no kx_restart.

Source files
------------

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core.
// One round per clock: initial AddRoundKey, nine full rounds, and a final
// round without MixColumns. The upstream key expansion is restarted through
// kx_restart so that the key for round r arrives in round-cycle r. The
// ciphertext is registered and held, with done set, until the next accepted
// start.
module aes_cipher_core #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] round_key,
  output logic         ready,
  output logic         kx_restart,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  // Only AES-128 is implemented; any other round count is a configuration error.
  if (NR != 10) begin : g_nr_check
    $error("aes_cipher_core: only NR = 10 (AES-128) is supported");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] LAST_RND = 4'(NR);

  // FIPS-197 S-box. Element 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte n of the block is bits [127-8n -: 8]; byte n sits at row n%4,
  // column n/4 (column-major state).

  // SubBytes followed by ShiftRows: output (row r, col c) takes the
  // substituted input byte at (row r, col (c+r)%4).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = SBOX[s[127-8*(4*((c+row)%4)+row) -: 8]];
      end
    end
    return r;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns with matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] ct_q, ct_d;
  logic         done_q, done_d;

  logic         accept;
  logic [127:0] ss_w;
  logic [127:0] mc_w;

  assign busy       = (state_q == ROUND);
  assign ready      = !busy;
  assign accept     = start & ready;
  assign kx_restart = accept;
  assign done       = done_q;
  assign ciphertext = ct_q;

  assign ss_w = sub_shift(st_q);
  assign mc_w = mix_columns(ss_w);

  // Next-state logic: accept a block, or advance one round while in ROUND.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave a value
    // unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    st_d    = st_q;
    ct_d    = ct_q;
    done_d  = done_q;

    if (accept) begin
      pt_d    = plaintext;
      cnt_d   = 4'd0;
      done_d  = 1'b0;
      state_d = ROUND;
    end else if (state_q == ROUND) begin
      if (cnt_q == 4'd0) begin
        st_d = pt_q ^ round_key;
      end else if (cnt_q == LAST_RND) begin
        ct_d    = ss_w ^ round_key;
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        st_d = mc_w ^ round_key;
      end
      // The counter saturates at the last round and then holds.
      if (cnt_q != LAST_RND) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are cleared too, so a reset mid-block
    // discards the partial state and the output reads zero afterwards.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pt_q    <= '0;
      st_q    <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      st_q    <= st_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Testbench for aes_cipher_core.
// A behavioural key expansion (with an S-box derived from GF(2^8) inversion
// and the affine map) feeds round keys and restarts on kx_restart. Expected
// ciphertexts and their due cycles are queued at acceptance and compared when
// done rises.
module tb_aes_cipher_core;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R1_C  = 128'h89d810e8855ace682d1843d8cb128fe4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] round_key;
  logic         ready;
  logic         kx_restart;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;

  logic [127:0] key;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] last_ct = '0;
  logic         done_seen = 1'b0;

  logic [7:0]        sb_tab [256];
  logic [0:10][127:0] kx_keys = '0;
  logic [3:0]        kx_idx = 4'd0;

  aes_cipher_core #(.NR(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .plaintext  (plaintext),
    .round_key  (round_key),
    .ready      (ready),
    .kx_restart (kx_restart),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse, then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gf_mul(b, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  function automatic logic [0:10][127:0] expand(input logic [127:0] k);
    logic [31:0]        w [44];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [0:10][127:0] rk;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gf_xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  // Behavioural key expansion: restarts on kx_restart or system reset.
  always @(posedge clk) begin
    if (reset || kx_restart) begin
      kx_idx  <= 4'd0;
      kx_keys <= expand(key);
    end else if (kx_idx < 4'd10) begin
      kx_idx <= kx_idx + 4'd1;
    end
  end

  assign round_key = kx_keys[kx_idx];

  // Scoreboard: on each rising done, compare ciphertext and arrival cycle.
  always @(negedge clk) begin
    if (reset) begin
      last_ct   <= '0;
      done_seen <= 1'b0;
    end else begin
      if (done && !done_seen) begin
        check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          check("ciphertext", ciphertext, sb[0].ct);
          check("latency", 128'(cyc), 128'(sb[0].due));
          last_ct <= sb[0].ct;
          void'(sb.pop_front());
        end
      end
      done_seen <= done;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Accept one block and watch the 11 busy cycles. Returns #1 into cycle T+12.
  task automatic run_block(input logic [127:0] key_v, input logic [127:0] pt_v,
                           input logic [127:0] ct_v, input bit chk_r1,
                           input logic [127:0] r1_v, input int intrude_at,
                           input bit hold);
    key       = key_v;
    plaintext = pt_v;
    start     = 1'b1;
    @(negedge clk);
    check("acc_ready", 128'(ready), 128'(1));
    check("acc_kx_restart", 128'(kx_restart), 128'(1));
    sb.push_back('{ct_v, cyc + 12});
    next_cycle();
    for (int i = 1; i <= 11; i++) begin
      start = hold || (i == intrude_at);
      if (i == intrude_at) plaintext = ~pt_v;
      @(negedge clk);
      check("run_busy", 128'(busy), 128'(1));
      check("run_ready", 128'(ready), 128'(0));
      check("run_kx_restart", 128'(kx_restart), 128'(0));
      check("run_done", 128'(done), 128'(0));
      check("run_ct_held", ciphertext, last_ct);
      if (i == 2) check("st_round0", dut.st_q, pt_v ^ key_v);
      if (i == 3 && chk_r1) check("st_round1", dut.st_q, r1_v);
      next_cycle();
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
    check("drain", 128'(sb.size()), 128'(0));
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));
    reset     = 1'b1;
    start     = 1'b0;
    key       = '0;
    plaintext = '0;
    repeat (3) next_cycle();

    // Reset state.
    @(negedge clk);
    check("rst_ready", 128'(ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_kx_restart", 128'(kx_restart), 128'(0));
    check("rst_ct", ciphertext, 128'(0));
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // FIPS-197 Appendix B.
    run_block(KEY_B, PT_B, CT_B, 1'b0, '0, 0, 1'b0);
    drain();

    // FIPS-197 Appendix C.1 with the round-1 intermediate state.
    run_block(KEY_C, PT_C, CT_C, 1'b1, R1_C, 0, 1'b0);
    drain();

    // Hold in DONE with plaintext toggling.
    for (int i = 0; i < 20; i++) begin
      start     = 1'b0;
      plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      check("hold_done", 128'(done), 128'(1));
      check("hold_busy", 128'(busy), 128'(0));
      check("hold_kx_restart", 128'(kx_restart), 128'(0));
      check("hold_ct", ciphertext, CT_C);
      next_cycle();
    end

    // Start pulsed while busy at T+5 with different plaintext.
    run_block(KEY_B, PT_B, CT_B, 1'b0, '0, 5, 1'b0);
    drain();

    // Back-to-back with start held: B then C.1.
    run_block(KEY_B, PT_B, CT_B, 1'b0, '0, 0, 1'b1);
    key       = KEY_C;
    plaintext = PT_C;
    run_block(KEY_C, PT_C, CT_C, 1'b1, R1_C, 0, 1'b0);
    drain();

    // Reset asserted in cycle T+6 of a running block.
    key       = KEY_B;
    plaintext = PT_B;
    start     = 1'b1;
    @(negedge clk);
    check("mid_acc_kx_restart", 128'(kx_restart), 128'(1));
    next_cycle();
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy_before", 128'(busy), 128'(1));
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 128'(ready), 128'(1));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_done", 128'(done), 128'(0));
    check("mid_rst_ct", ciphertext, 128'(0));
    next_cycle();
    run_block(KEY_C, PT_C, CT_C, 1'b1, R1_C, 0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
